spawn_coord_scheduler: RTL
==========================

Name: spawn_coord_scheduler

Overview:
- Shares the pseudorandom source between several sprite spawners (coins, hazards, power-ups) and returns legal spawn coordinates in the 640 x 480 display area.
- Samples the free-running LFSR outputs, applies rejection sampling against screen bounds and a keep-out box around the player, and falls back to a fixed coordinate after too many rejections.
- Sits between the LFSR and the sprite control logic. Requesters are arbitrated round-robin.

Parameters:
- N_REQ, 2, number of requesters (2..4)
- SPRITE_W, 16, sprite width; legal x is 0..639-SPRITE_W
- SPRITE_H, 16, sprite height; legal y is 0..479-SPRITE_H
- EXCL, 48, half-size of the keep-out box around the player
- MAX_TRIES, 8, candidate attempts before fallback (1..15)
- FALLBACK_X, 320, x used when tries are exhausted
- FALLBACK_Y, 240, y used when tries are exhausted

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- lfsr_q1  in  50  LFSR 50-bit state; bits [9:0] give candidate x
- lfsr_q2  in  20  LFSR 20-bit state; bits [8:0] give candidate y
- player_x  in  10  current player x
- player_y  in  9  current player y
- req  in  N_REQ  per-requester spawn request, level, held until ack
- ack  out  N_REQ  one-hot, one-cycle pulse; result valid this cycle
- spawn_x  out  10  granted x, held until next ack
- spawn_y  out  9  granted y, held until next ack
- fallback  out  1  set with ack when the fallback coordinate was used
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE, ack=0, spawn_x=0, spawn_y=0, fallback=0, busy=0, rr pointer=0, try counter=0.
- The block is clocked by clk only. The lfsr inputs change every cycle and are treated as already-registered.
- FSM states are IDLE, SAMPLE, CHECK, DONE.
- IDLE: if any req bit is set, register the winner index and go to SAMPLE; the try counter is cleared.
  - The winner is the first set req bit at or after the rr pointer, wrapping modulo N_REQ.
- SAMPLE: latch cx=lfsr_q1[9:0] and cy=lfsr_q2[8:0]; go to CHECK.
- CHECK: the candidate is accepted iff all three hold:
  - cx <= 639-SPRITE_W
  - cy <= 479-SPRITE_H
  - NOT (|cx-player_x| < EXCL AND |cy-player_y| < EXCL)
- Absolute differences are computed at 11 bits unsigned; the comparison is strict (<).
- CHECK transitions:
  - Accept: go to DONE with the candidate.
  - Reject with try counter == MAX_TRIES-1: go to DONE with FALLBACK_X/FALLBACK_Y and fallback=1. The fallback is not itself checked.
  - Otherwise: increment the try counter and return to SAMPLE.
- DONE: register spawn_x/spawn_y/fallback, pulse ack[winner] for exactly one cycle, set the rr pointer to winner+1 mod N_REQ, then return to IDLE.
- Latency from req seen in IDLE to ack:
  - best case 3 cycles (IDLE->SAMPLE->CHECK->DONE)
  - worst case 2*MAX_TRIES+1 cycles
- Requester protocol:
  - The requester must drop req in the cycle after ack. If it does not, it is re-queued behind the others by the rr rule.
  - The block is back in IDLE the cycle after DONE, so back-to-back grants are one cycle apart.
- Abort: if req[winner] deasserts while in SAMPLE or CHECK, go to IDLE next cycle.
  - No ack is issued.
  - spawn_x/spawn_y/fallback are unchanged.
  - The rr pointer is unchanged.
- Simultaneous requests: only one winner per transaction. The others stay pending and are served in rr order.
- player_x/player_y are sampled live in CHECK; a move between tries affects later tries.
- Reset asserted mid-transaction returns everything to reset values immediately. No ack is issued.
- fallback is cleared on every non-fallback ack.

Decomposition:
- Shared package spawn_pkg holds:
  - SCREEN_W=640, SCREEN_H=480
  - coordinate widths X_W=10, Y_W=9
  - the state enum encoding
- One natural sub-module: rr_arbiter (N_REQ inputs, pointer in, one-hot/index out, purely combinational pick).
- The keep-out check stays inline.

Test Plan:
- Single request, first candidate legal: lfsr_q1[9:0]=100, lfsr_q2[8:0]=50, player=(400,300), req=01 -> ack=01 three cycles after req, spawn=(100,50), fallback=0.
- Bounds rejection: candidate x=630 then x=200 (y=100), player far away -> one retry; ack after 5 cycles, spawn=(200,100).
- Keep-out rejection then fallback: every candidate equals player=(300,200) -> after MAX_TRIES=8 tries ack at cycle 17, spawn=(320,240), fallback=1.
- Round-robin: req=11 held continuously with legal candidates -> ack sequence 01, 10, 01, 10 with one idle cycle between grants.
- Abort: req=01 then dropped during CHECK of a rejected try -> no ack, busy low next cycle, rr pointer unchanged (next req=11 grants requester 0).
- Reset mid-operation: rst pulsed in CHECK -> ack=0, spawn=(0,0), busy=0; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/spawn_coord_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spawn_pkg
//  Description : Shared constants, state encoding and helpers for the spawn
//                coordinate scheduler (screen size, coordinate widths, FSM).
//  Revision    : 1.0  initial release
// ============================================================================
package spawn_pkg;

    // Visible display area
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Coordinate widths; D_W is one bit wider than X_W so that absolute
    // differences of x and y share a single unsigned width
    localparam int X_W = 10;
    localparam int Y_W = 9;
    localparam int D_W = X_W + 1;

    // Scheduler state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SAMPLE = 2'b01,
        ST_CHECK  = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    // Unsigned |a - b|
    function automatic logic [D_W-1:0] abs_diff(input logic [D_W-1:0] a,
                                                input logic [D_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage : spawn_pkg
`default_nettype wire

// File: rtl/spawn_coord_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Purely combinational round-robin pick. Returns the first set
//                request at or after the pointer, wrapping modulo N_REQ.
//  Ports       : i_req   - request vector
//                i_ptr   - priority pointer (must be < N_REQ)
//                o_grant - one-hot winner
//                o_idx   - winner index
//                o_any   - at least one request present
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
    import spawn_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    localparam logic [IDX_W:0] c_N = (IDX_W+1)'(N_REQ);

    always_comb begin : p_pick
        logic [IDX_W:0]   w_sum;
        logic [IDX_W-1:0] w_pos;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_sum   = '0;
        w_pos   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // Candidate position ptr+k, folded back into 0..N_REQ-1
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_sum >= c_N) begin
                w_sum = w_sum - c_N;
            end
            w_pos = w_sum[IDX_W-1:0];
            if (!o_any && i_req[w_pos]) begin
                o_any          = 1'b1;
                o_idx          = w_pos;
                o_grant[w_pos] = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/spawn_coord_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : spawn_coord_scheduler
//  Description : Shares a free-running LFSR between several sprite spawners.
//                A round-robin winner gets a candidate (x, y) drawn from the
//                LFSR; candidates off-screen or inside the keep-out box around
//                the player are rejected and redrawn, up to MAX_TRIES times,
//                after which a fixed fallback coordinate is returned.
//  Ports       : clk, rst          - clock, asynchronous active-high reset
//                lfsr_q1[9:0]      - candidate x source
//                lfsr_q2[8:0]      - candidate y source
//                player_x/player_y - live player position
//                req               - level request per requester
//                ack               - one-hot, one-cycle result strobe
//                spawn_x/spawn_y   - granted coordinate, held between acks
//                fallback          - set with ack if fallback was used
//                busy              - FSM not in IDLE
//  Revision    : 1.0  initial release
// ============================================================================
module spawn_coord_scheduler
    import spawn_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int SPRITE_W   = 16,
    parameter int SPRITE_H   = 16,
    parameter int EXCL       = 48,
    parameter int MAX_TRIES  = 8,
    parameter int FALLBACK_X = 320,
    parameter int FALLBACK_Y = 240
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [49:0]      lfsr_q1,
    input  logic [19:0]      lfsr_q2,
    input  logic [X_W-1:0]   player_x,
    input  logic [Y_W-1:0]   player_y,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] ack,
    output logic [X_W-1:0]   spawn_x,
    output logic [Y_W-1:0]   spawn_y,
    output logic             fallback,
    output logic             busy
);

    localparam int             c_IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int             c_TRY_W    = 4;
    localparam logic [X_W-1:0] c_X_MAX    = X_W'(SCREEN_W - 1 - SPRITE_W);
    localparam logic [Y_W-1:0] c_Y_MAX    = Y_W'(SCREEN_H - 1 - SPRITE_H);
    localparam logic [D_W-1:0] c_EXCL     = D_W'(EXCL);
    localparam logic [X_W-1:0] c_FB_X     = X_W'(FALLBACK_X);
    localparam logic [Y_W-1:0] c_FB_Y     = Y_W'(FALLBACK_Y);
    localparam logic [c_TRY_W-1:0] c_LAST_TRY = c_TRY_W'(MAX_TRIES - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N_REQ - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               r_state_q,      w_state_d;
    logic [c_IDX_W-1:0]   r_winner_idx_q, w_winner_idx_d;
    logic [N_REQ-1:0]     r_winner_oh_q,  w_winner_oh_d;
    logic [c_IDX_W-1:0]   r_ptr_q,        w_ptr_d;
    logic [c_TRY_W-1:0]   r_tries_q,      w_tries_d;
    logic [X_W-1:0]       r_cx_q,         w_cx_d;
    logic [Y_W-1:0]       r_cy_q,         w_cy_d;
    logic [N_REQ-1:0]     r_ack_q,        w_ack_d;
    logic [X_W-1:0]       r_spawn_x_q,    w_spawn_x_d;
    logic [Y_W-1:0]       r_spawn_y_q,    w_spawn_y_d;
    logic                 r_fallback_q,   w_fallback_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [N_REQ-1:0]   w_arb_grant;
    logic [c_IDX_W-1:0] w_arb_idx;
    logic               w_arb_any;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (c_IDX_W)
    ) u_rr_arbiter (
        .i_req   (req),
        .i_ptr   (r_ptr_q),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    // ------------------------------------------------------------------
    // Candidate legality: on-screen and outside the player keep-out box
    // ------------------------------------------------------------------
    logic [D_W-1:0] w_dx;
    logic [D_W-1:0] w_dy;
    logic           w_in_bounds;
    logic           w_in_keepout;
    logic           w_accept;
    logic           w_winner_live;

    assign w_dx         = abs_diff({1'b0, r_cx_q}, {1'b0, player_x});
    assign w_dy         = abs_diff({2'b00, r_cy_q}, {2'b00, player_y});
    assign w_in_bounds  = (r_cx_q <= c_X_MAX) && (r_cy_q <= c_Y_MAX);
    assign w_in_keepout = (w_dx < c_EXCL) && (w_dy < c_EXCL);
    assign w_accept     = w_in_bounds && !w_in_keepout;

    // Winner still requesting; dropping it mid-transaction aborts quietly
    assign w_winner_live = |(req & r_winner_oh_q);

    // Only the low LFSR bits are used for candidates
    logic w_unused_lfsr;
    assign w_unused_lfsr = ^{lfsr_q1[49:X_W], lfsr_q2[19:Y_W]};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d      = r_state_q;
        w_winner_idx_d = r_winner_idx_q;
        w_winner_oh_d  = r_winner_oh_q;
        w_ptr_d        = r_ptr_q;
        w_tries_d      = r_tries_q;
        w_cx_d         = r_cx_q;
        w_cy_d         = r_cy_q;
        w_ack_d        = '0;
        w_spawn_x_d    = r_spawn_x_q;
        w_spawn_y_d    = r_spawn_y_q;
        w_fallback_d   = r_fallback_q;

        case (r_state_q)
            ST_IDLE: begin
                if (w_arb_any) begin
                    w_winner_idx_d = w_arb_idx;
                    w_winner_oh_d  = w_arb_grant;
                    w_tries_d      = '0;
                    w_state_d      = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                if (!w_winner_live) begin
                    w_state_d = ST_IDLE;
                end else begin
                    w_cx_d    = lfsr_q1[X_W-1:0];
                    w_cy_d    = lfsr_q2[Y_W-1:0];
                    w_state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (!w_winner_live) begin
                    w_state_d = ST_IDLE;
                end else if (w_accept) begin
                    // Result registers load here so they are valid with ack
                    w_spawn_x_d  = r_cx_q;
                    w_spawn_y_d  = r_cy_q;
                    w_fallback_d = 1'b0;
                    w_ack_d      = r_winner_oh_q;
                    w_state_d    = ST_DONE;
                end else if (r_tries_q == c_LAST_TRY) begin
                    w_spawn_x_d  = c_FB_X;
                    w_spawn_y_d  = c_FB_Y;
                    w_fallback_d = 1'b1;
                    w_ack_d      = r_winner_oh_q;
                    w_state_d    = ST_DONE;
                end else begin
                    w_tries_d = r_tries_q + 1'b1;
                    w_state_d = ST_SAMPLE;
                end
            end

            ST_DONE: begin
                // ack is high during this state; rotate priority past winner
                w_ptr_d   = (r_winner_idx_q == c_LAST_IDX) ? '0
                                                           : r_winner_idx_q + 1'b1;
                w_state_d = ST_IDLE;
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q      <= ST_IDLE;
            r_winner_idx_q <= '0;
            r_winner_oh_q  <= '0;
            r_ptr_q        <= '0;
            r_tries_q      <= '0;
            r_cx_q         <= '0;
            r_cy_q         <= '0;
            r_ack_q        <= '0;
            r_spawn_x_q    <= '0;
            r_spawn_y_q    <= '0;
            r_fallback_q   <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_winner_idx_q <= w_winner_idx_d;
            r_winner_oh_q  <= w_winner_oh_d;
            r_ptr_q        <= w_ptr_d;
            r_tries_q      <= w_tries_d;
            r_cx_q         <= w_cx_d;
            r_cy_q         <= w_cy_d;
            r_ack_q        <= w_ack_d;
            r_spawn_x_q    <= w_spawn_x_d;
            r_spawn_y_q    <= w_spawn_y_d;
            r_fallback_q   <= w_fallback_d;
        end
    end

    assign ack      = r_ack_q;
    assign spawn_x  = r_spawn_x_q;
    assign spawn_y  = r_spawn_y_q;
    assign fallback = r_fallback_q;
    assign busy     = (r_state_q != ST_IDLE);

endmodule : spawn_coord_scheduler
`default_nettype wire
